// File: rtl/write_arbiter_pkg.sv
// rtl/write_arbiter_pkg.sv - shared FSM encodings and width helper for the write arbiter
// Contents:
//   state_t : arbiter FSM states (idle / issue strobe / wait for ack)
//   clog2   : ceil(log2(value)), minimum 1, usable in constant expressions
package write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/write_arbiter_if.sv
// rtl/write_arbiter_if.sv - requester and memory-port bundle of the write arbiter
// Signals:
//   req, req_addr, req_data   : per-requester level request and packed address/data slots
//   done, err                 : per-requester completion / timeout pulses
//   mem_wr_en, mem_addr,
//   mem_data, mem_ack         : shared memory write port
//   busy                      : arbiter is issuing or waiting
// Modports: slave = arbiter side, master = requesters + memory side
interface write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        err;
  logic                    mem_wr_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_ack;
  logic                    busy;

  modport slave (
    input  req, req_addr, req_data, mem_ack,
    output done, err, mem_wr_en, mem_addr, mem_data, busy
  );

  modport master (
    output req, req_addr, req_data, mem_ack,
    input  done, err, mem_wr_en, mem_addr, mem_data, busy
  );

endinterface

// File: rtl/write_arbiter_written_pulse.sv
// rtl/write_arbiter_written_pulse.sv - rising-edge detector turning a level request into one pulse
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   level      : requester level request
//   pulse      : registered one-cycle pulse per rising edge of level
module write_arbiter_written_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - round-robin arbiter sharing one memory write port among requesters
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : write_arbiter_if.slave (requests, done/err pulses, memory write port, busy)
// Parameters: N_REQ requesters, ADDR_W/DATA_W write widths, ACK_TIMEOUT wait limit
module write_arbiter
  import write_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  write_arbiter_if.slave   bus
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2(ACK_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pulse, pending, pend_clr, win_oh;
  logic [N_REQ-1:0]   done_q, err_q;
  logic [PTR_W-1:0]   rr_ptr, winner, win_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               grant, ack_hit, to_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_pulse
    write_arbiter_written_pulse u_pulse (
      .clk   (clk),
      .reset (reset),
      .level (bus.req[i]),
      .pulse (pulse[i])
    );
  end

  // First pending bit at or above rr_ptr, wrapping; modulo keeps
  // non-power-of-two N_REQ from selecting a nonexistent slot.
  always_comb begin : arb_sel
    int j;
    j       = 0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (pending[j]) win_idx = PTR_W'(j);
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Ack on the timeout cycle still counts as success.
        if (bus.mem_ack) begin
          ack_hit = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          to_hit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
  assign pend_clr = (ack_hit | to_hit) ? win_oh : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      rr_ptr  <= '0;
      winner  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      // A new pulse on the clearing cycle keeps the bit set.
      pending <= (pending & ~pend_clr) | pulse;
      done_q  <= ack_hit ? win_oh : '0;
      err_q   <= to_hit  ? win_oh : '0;
      if (grant) begin
        winner <= win_idx;
        addr_q <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
        data_q <= bus.req_data[win_idx*DATA_W +: DATA_W];
      end
      if (state_q == ST_ISSUE)     cnt_q <= '0;
      else if (state_d == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      if (ack_hit | to_hit)
        rr_ptr <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign bus.mem_wr_en = (state_q == ST_ISSUE);
  assign bus.busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - self-checking bench for write_arbiter
module tb_write_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0, done_total = 0, err_total = 0, multi = 0;

  write_arbiter_if #(.N_REQ(4), .ADDR_W(12), .DATA_W(32)) bus ();

  write_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(32), .ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_wr_en) wr_cnt++;
    if (bus.done != 0) done_total++;
    if (bus.err != 0) err_total++;
    if ($countones({bus.done, bus.err}) > 1) multi++;
  end

  typedef struct {
    int          idx;
    logic [11:0] addr;
    logic [31:0] data;
    int          ack_at;   // WAIT-cycle index at which ack is driven, 0 = never
    logic [3:0]  exp_done;
    logic [3:0]  exp_err;
    int          exp_end;  // cycles after the wr_en cycle when done/err shows
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [11:0] a, input logic [31:0] d);
    bus.req_addr[i*12 +: 12] = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  // Waits up to limit negedges for mem_wr_en; returns edges waited or -1.
  task automatic wait_wr(input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic wait_fin(input int limit, output logic [3:0] d, output logic [3:0] e, output int n);
    n = -1; d = '0; e = '0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != 0) begin
        d = bus.done; e = bus.err; n = c;
        break;
      end
    end
  endtask

  initial begin
    int n, t, w0, d0, e0;
    logic [3:0] got_d, got_e;
    logic [3:0] order[4];

    vecs[0] = '{2, 12'h0A5, 32'hDEADBEEF, 2,  4'b0100, 4'b0000, 3};
    vecs[1] = '{0, 12'hFFF, 32'h00000000, 1,  4'b0001, 4'b0000, 2};
    vecs[2] = '{3, 12'h000, 32'hFFFFFFFF, 16, 4'b1000, 4'b0000, 17};
    vecs[3] = '{1, 12'h5A5, 32'h12345678, 0,  4'b0000, 4'b0010, 17};
    vecs[4] = '{1, 12'h123, 32'hA5A5A5A5, 15, 4'b0010, 4'b0000, 16};

    reset = 1'b0;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done_err", {bus.done, bus.err}, 0);
    check("rst_addr_data", {bus.mem_addr, bus.mem_data}, 0);
    reset = 1'b1;
    @(negedge clk);

    // All four rise together with ack held: round-robin from slot 0.
    for (int i = 0; i < 4; i++) set_slot(i, 12'h100 + 12'(i), 32'h1000 + 32'(i));
    bus.mem_ack = 1'b1;
    bus.req = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.done != 0) begin order[n] = bus.done; n++; end
    end
    check("rr4_count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr4_order%0d", i), order[i], 4'b0001 << i);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Pointer back at 0: slots 3 and 0 together must grant 0 first.
    bus.req = 4'b1001;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (bus.done != 0) begin order[n] = bus.done; n++; end
    end
    check("rr_wrap_count", n, 2);
    check("rr_wrap_first", order[0], 4'b0001);
    check("rr_wrap_second", order[1], 4'b1000);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Held level yields one write; drop and re-raise yields exactly one more.
    w0 = wr_cnt;
    set_slot(1, 12'h011, 32'h11);
    bus.req[1] = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_one_write", wr_cnt - w0, 1);
    bus.req[1] = 1'b0;
    @(negedge clk);
    bus.req[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("reraise_one_more", wr_cnt - w0, 2);
    bus.req[1] = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      set_slot(vecs[v].idx, vecs[v].addr, vecs[v].data);
      bus.req[vecs[v].idx] = 1'b1;
      wait_wr(10, n);
      check($sformatf("v%0d_latency", v), n, 3);
      if (n > 0) begin
        check($sformatf("v%0d_addr", v), bus.mem_addr, vecs[v].addr);
        check($sformatf("v%0d_data", v), bus.mem_data, vecs[v].data);
        got_d = '0; got_e = '0; t = -1;
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          if (c == 1) check($sformatf("v%0d_wr_one", v), bus.mem_wr_en, 0);
          if ((bus.done | bus.err) != 0) begin
            got_d = bus.done; got_e = bus.err; t = c;
            break;
          end
          bus.mem_ack = (c == vecs[v].ack_at);
        end
        bus.mem_ack = 1'b0;
        check($sformatf("v%0d_done", v), got_d, vecs[v].exp_done);
        check($sformatf("v%0d_err", v), got_e, vecs[v].exp_err);
        check($sformatf("v%0d_end", v), t, vecs[v].exp_end);
        @(negedge clk);
        check($sformatf("v%0d_pulse_one", v), {bus.done, bus.err}, 0);
        check($sformatf("v%0d_hold", v), bus.mem_addr, vecs[v].addr);
      end
      bus.req[vecs[v].idx] = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Timeout, then the waiting requester is granted right after err.
    set_slot(2, 12'h222, 32'h2222);
    set_slot(3, 12'h333, 32'h3333);
    bus.req[2] = 1'b1;
    wait_wr(10, n);
    check("to_first_wr", n, 3);
    @(negedge clk);
    bus.req[3] = 1'b1;
    wait_fin(25, got_d, got_e, n);
    check("to_err", {got_d, got_e}, {4'b0000, 4'b0100});
    @(negedge clk);
    check("to_next_wr", bus.mem_wr_en, 1);
    check("to_next_addr", bus.mem_addr, 12'h333);
    bus.mem_ack = 1'b1;
    wait_fin(10, got_d, got_e, n);
    check("to_next_done", {got_d, got_e}, {4'b1000, 4'b0000});
    bus.mem_ack = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Re-raise of slot 3 landing on its own clearing cycle.
    set_slot(3, 12'h3C3, 32'h66);
    bus.req[3] = 1'b1;
    wait_wr(10, n);
    check("rr3_first_wr", n, 3);
    bus.req[3] = 1'b0;
    @(negedge clk);
    bus.req[3] = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("rr3_done1", bus.done, 4'b1000);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("rr3_second_wr", bus.mem_wr_en, 1);
    bus.mem_ack = 1'b1;
    wait_fin(10, got_d, got_e, n);
    check("rr3_done2", {got_d, got_e}, {4'b1000, 4'b0000});
    bus.mem_ack = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset in WAIT aborts silently; nothing stale afterwards.
    set_slot(0, 12'h0F0, 32'hF0);
    bus.req[0] = 1'b1;
    wait_wr(10, n);
    check("rst_mid_wr", n, 3);
    @(negedge clk);
    check("rst_mid_busy_before", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_async", {bus.mem_wr_en, bus.busy, bus.done, bus.err}, 0);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    w0 = wr_cnt; d0 = done_total; e0 = err_total;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_stale", {8'(wr_cnt - w0), 8'(done_total - d0), 8'(err_total - e0)}, 0);

    check("never_multi_hot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
